// File: rtl/sc_psr_cond_pkg.sv
// Shared definitions for the PSR condition-code block: icc bit positions,
// SPARC branch condition encodings, FSM state encodings and widths.
package sc_psr_pkg;

  localparam int DATAWIDTH_ICC     = 4;
  localparam int DATAWIDTH_COND    = 4;
  localparam int DATAWIDTH_OVCOUNT = 8;

  // icc bit order {N,Z,V,C}
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  localparam logic [DATAWIDTH_OVCOUNT-1:0] OVCOUNT_MAX  = {DATAWIDTH_OVCOUNT{1'b1}};
  localparam logic [DATAWIDTH_OVCOUNT-1:0] OVCOUNT_ONE  = {{(DATAWIDTH_OVCOUNT-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH_OVCOUNT-1:0] OVCOUNT_ZERO = {DATAWIDTH_OVCOUNT{1'b0}};
  localparam logic [DATAWIDTH_ICC-1:0]     ICC_ZERO     = {DATAWIDTH_ICC{1'b0}};

  // SPARC integer branch conditions
  localparam logic [DATAWIDTH_COND-1:0] COND_BN   = 4'b0000;
  localparam logic [DATAWIDTH_COND-1:0] COND_BE   = 4'b0001;
  localparam logic [DATAWIDTH_COND-1:0] COND_BLE  = 4'b0010;
  localparam logic [DATAWIDTH_COND-1:0] COND_BL   = 4'b0011;
  localparam logic [DATAWIDTH_COND-1:0] COND_BLEU = 4'b0100;
  localparam logic [DATAWIDTH_COND-1:0] COND_BCS  = 4'b0101;
  localparam logic [DATAWIDTH_COND-1:0] COND_BNEG = 4'b0110;
  localparam logic [DATAWIDTH_COND-1:0] COND_BVS  = 4'b0111;
  localparam logic [DATAWIDTH_COND-1:0] COND_BA   = 4'b1000;
  localparam logic [DATAWIDTH_COND-1:0] COND_BNE  = 4'b1001;
  localparam logic [DATAWIDTH_COND-1:0] COND_BG   = 4'b1010;
  localparam logic [DATAWIDTH_COND-1:0] COND_BGE  = 4'b1011;
  localparam logic [DATAWIDTH_COND-1:0] COND_BGU  = 4'b1100;
  localparam logic [DATAWIDTH_COND-1:0] COND_BCC  = 4'b1101;
  localparam logic [DATAWIDTH_COND-1:0] COND_BPOS = 4'b1110;
  localparam logic [DATAWIDTH_COND-1:0] COND_BVC  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    RESP = 2'b10
  } psrState_t;

  // Convert the ALU's active-low flags into an active-high {N,Z,V,C} word.
  function automatic logic [DATAWIDTH_ICC-1:0] packFlags(
    input logic negativeLow,
    input logic zeroLow,
    input logic overflowLow,
    input logic carryLow
  );
    logic [DATAWIDTH_ICC-1:0] flags;
    flags        = ICC_ZERO;
    flags[ICC_N] = ~negativeLow;
    flags[ICC_Z] = ~zeroLow;
    flags[ICC_V] = ~overflowLow;
    flags[ICC_C] = ~carryLow;
    return flags;
  endfunction

endpackage

// File: rtl/sc_psr_cond_if.sv
// Bus between ALU / control unit (master) and the PSR condition block (slave).
interface sc_psr_cond_if;
  import sc_psr_pkg::*;

  logic                         SC_PSR_overflow_InLow;
  logic                         SC_PSR_carry_InLow;
  logic                         SC_PSR_negative_InLow;
  logic                         SC_PSR_zero_InLow;
  logic                         SC_PSR_setcc_InHigh;
  logic                         SC_PSR_wrpsr_InHigh;
  logic [DATAWIDTH_ICC-1:0]     SC_PSR_data_InBUS;
  logic [DATAWIDTH_COND-1:0]    SC_PSR_cond_InBUS;
  logic                         SC_PSR_evalReq_InHigh;
  logic                         SC_PSR_evalAck_OutHigh;
  logic                         SC_PSR_taken_OutHigh;
  logic                         SC_PSR_busy_OutHigh;
  logic [DATAWIDTH_ICC-1:0]     SC_PSR_icc_OutBUS;
  logic [DATAWIDTH_OVCOUNT-1:0] SC_PSR_ovCount_OutBUS;

  modport master (
    output SC_PSR_overflow_InLow, SC_PSR_carry_InLow, SC_PSR_negative_InLow,
           SC_PSR_zero_InLow, SC_PSR_setcc_InHigh, SC_PSR_wrpsr_InHigh,
           SC_PSR_data_InBUS, SC_PSR_cond_InBUS, SC_PSR_evalReq_InHigh,
    input  SC_PSR_evalAck_OutHigh, SC_PSR_taken_OutHigh, SC_PSR_busy_OutHigh,
           SC_PSR_icc_OutBUS, SC_PSR_ovCount_OutBUS
  );

  modport slave (
    input  SC_PSR_overflow_InLow, SC_PSR_carry_InLow, SC_PSR_negative_InLow,
           SC_PSR_zero_InLow, SC_PSR_setcc_InHigh, SC_PSR_wrpsr_InHigh,
           SC_PSR_data_InBUS, SC_PSR_cond_InBUS, SC_PSR_evalReq_InHigh,
    output SC_PSR_evalAck_OutHigh, SC_PSR_taken_OutHigh, SC_PSR_busy_OutHigh,
           SC_PSR_icc_OutBUS, SC_PSR_ovCount_OutBUS
  );

endinterface

// File: rtl/sc_psr_cond_eval.sv
// Combinational SPARC branch-condition decoder: icc + cond -> taken.
module sc_psr_cond_eval
  import sc_psr_pkg::*;
(
  input  logic [DATAWIDTH_ICC-1:0]  icc,
  input  logic [DATAWIDTH_COND-1:0] cond,
  output logic                      taken
);

  logic n_s;
  logic z_s;
  logic v_s;
  logic c_s;

  assign n_s = icc[ICC_N];
  assign z_s = icc[ICC_Z];
  assign v_s = icc[ICC_V];
  assign c_s = icc[ICC_C];

  // Decode the condition field against the flags.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BN:   taken = 1'b0;
      COND_BE:   taken = z_s;
      COND_BLE:  taken = z_s | (n_s ^ v_s);
      COND_BL:   taken = n_s ^ v_s;
      COND_BLEU: taken = c_s | z_s;
      COND_BCS:  taken = c_s;
      COND_BNEG: taken = n_s;
      COND_BVS:  taken = v_s;
      COND_BA:   taken = 1'b1;
      COND_BNE:  taken = ~z_s;
      COND_BG:   taken = ~(z_s | (n_s ^ v_s));
      COND_BGE:  taken = ~(n_s ^ v_s);
      COND_BGU:  taken = ~(c_s | z_s);
      COND_BCC:  taken = ~c_s;
      COND_BPOS: taken = ~n_s;
      COND_BVC:  taken = ~v_s;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sc_psr_cond.sv
// PSR integer condition codes: captures ALU flags / WRPSR writes into icc,
// counts overflow events, and answers branch-condition requests over req/ack.
// Build option: define SC_PSR_BYPASS_EN for the 1-cycle variant that evaluates
// on the next-icc value in IDLE and skips the EVAL state.
module sc_psr_cond
  import sc_psr_pkg::*;
(
  input  logic         SC_PSR_CLOCK_50,
  input  logic         SC_PSR_RESET_InHigh,
  sc_psr_cond_if.slave psrBus
);

  logic [DATAWIDTH_ICC-1:0]     aluFlags_s;
  logic [DATAWIDTH_ICC-1:0]     iccNext_s;
  logic [DATAWIDTH_ICC-1:0]     icc_r;
  logic [DATAWIDTH_OVCOUNT-1:0] ovCount_r;
  logic                         ovEvent_s;
  psrState_t                    state_r;
  psrState_t                    stateNext_s;
  logic                         takenLoad_s;
  logic                         taken_r;
  logic                         ack_r;
  logic                         busy_r;
  logic [DATAWIDTH_ICC-1:0]     evalIcc_s;
  logic [DATAWIDTH_COND-1:0]    evalCond_s;
  logic                         evalTaken_s;

  assign aluFlags_s = packFlags(psrBus.SC_PSR_negative_InLow, psrBus.SC_PSR_zero_InLow,
                                psrBus.SC_PSR_overflow_InLow, psrBus.SC_PSR_carry_InLow);

  // icc source mux: WRPSR wins over setcc, otherwise hold.
  always_comb begin
    iccNext_s = icc_r;
    if (psrBus.SC_PSR_wrpsr_InHigh) begin
      iccNext_s = psrBus.SC_PSR_data_InBUS;
    end else if (psrBus.SC_PSR_setcc_InHigh) begin
      iccNext_s = aluFlags_s;
    end else begin
      iccNext_s = icc_r;
    end
  end

  assign ovEvent_s = psrBus.SC_PSR_setcc_InHigh & ~psrBus.SC_PSR_wrpsr_InHigh & aluFlags_s[ICC_V];

  // icc register and saturating overflow counter.
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      icc_r     <= ICC_ZERO;
      ovCount_r <= OVCOUNT_ZERO;
    end else begin
      icc_r <= iccNext_s;
      if (ovEvent_s && (ovCount_r != OVCOUNT_MAX)) begin
        ovCount_r <= ovCount_r + OVCOUNT_ONE;
      end
    end
  end

`ifdef SC_PSR_BYPASS_EN
  // Bypass variant evaluates in IDLE on the post-mux icc and the live cond.
  assign evalIcc_s  = iccNext_s;
  assign evalCond_s = psrBus.SC_PSR_cond_InBUS;
`else
  logic [DATAWIDTH_COND-1:0] cond_r;
  logic                      condLoad_s;

  assign condLoad_s = (state_r == IDLE) & psrBus.SC_PSR_evalReq_InHigh;

  // Latch the branch condition when a request is accepted.
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      cond_r <= COND_BN;
    end else if (condLoad_s) begin
      cond_r <= psrBus.SC_PSR_cond_InBUS;
    end
  end

  assign evalIcc_s  = icc_r;
  assign evalCond_s = cond_r;
`endif

  sc_psr_cond_eval uEval (
    .icc   (evalIcc_s),
    .cond  (evalCond_s),
    .taken (evalTaken_s)
  );

  // Next-state logic and taken-capture strobe.
  always_comb begin
    stateNext_s = state_r;
    takenLoad_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (psrBus.SC_PSR_evalReq_InHigh) begin
`ifdef SC_PSR_BYPASS_EN
          stateNext_s = RESP;
          takenLoad_s = 1'b1;
`else
          stateNext_s = EVAL;
`endif
        end else begin
          stateNext_s = IDLE;
        end
      end
      EVAL: begin
`ifdef SC_PSR_BYPASS_EN
        stateNext_s = IDLE;
`else
        stateNext_s = RESP;
        takenLoad_s = 1'b1;
`endif
      end
      RESP:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // State register plus registered ack/busy/taken, all derived from next state.
  always_ff @(posedge SC_PSR_CLOCK_50) begin
    if (SC_PSR_RESET_InHigh) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      taken_r <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      ack_r   <= (stateNext_s == RESP);
      busy_r  <= (stateNext_s != IDLE);
      if (takenLoad_s) begin
        taken_r <= evalTaken_s;
      end
    end
  end

  assign psrBus.SC_PSR_evalAck_OutHigh = ack_r;
  assign psrBus.SC_PSR_taken_OutHigh   = taken_r;
  assign psrBus.SC_PSR_busy_OutHigh    = busy_r;
  assign psrBus.SC_PSR_icc_OutBUS      = icc_r;
  assign psrBus.SC_PSR_ovCount_OutBUS  = ovCount_r;

endmodule
